// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: drives buffer enables/clears
// and the PC write enable, and counts stall and flush events.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_R1_pos,
    input  logic [4:0]       id_R2_pos,
    input  logic             id_uses_R1,
    input  logic             id_uses_R2,
    input  logic [4:0]       ex_dst,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             wb_syscall,
    input  logic [31:0]      wb_v0,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             exmem_clr,
    output logic             memwb_en,
    output logic             memwb_clr,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    // Control vector order: pc_en, ifid en/clr, idex en/clr, exmem en/clr, memwb en/clr
    localparam logic [8:0] CTRL_RUN    = 9'b1_10_10_10_10;
    localparam logic [8:0] CTRL_OFF    = 9'b0_00_00_00_00;
    localparam logic [8:0] CTRL_FLUSH  = 9'b1_11_11_10_10;
    localparam logic [8:0] CTRL_STALL  = 9'b0_00_11_10_10;
    localparam logic [8:0] CTRL_RESUME = 9'b1_10_10_10_11;
    localparam logic [7:0] TIMEOUT     = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             halted_q, halted_d;
    logic             mem_err_q, mem_err_d;
    logic [8:0]       ctrl_s;
    logic             run_rules_s;
    logic             load_use_s;
    logic             halt_req_s;
    logic             freeze_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] max_v;
        max_v = '1;
        if (v == max_v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign load_use_s = ex_mem_read && (ex_dst != 5'd0) &&
                        ((id_uses_R1 && (id_R1_pos == ex_dst)) ||
                         (id_uses_R2 && (id_R2_pos == ex_dst)));
    assign halt_req_s = wb_syscall && (wb_v0 == 32'd10);
    assign freeze_s   = mem_req && !mem_ready;

    // Next-state, counter and buffer-control decode
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        halted_d    = halted_q;
        mem_err_d   = mem_err_q;
        ctrl_s      = CTRL_RUN;
        run_rules_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_req_s) begin
                    ctrl_s   = CTRL_OFF;
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (freeze_s) begin
                    ctrl_s  = CTRL_OFF;
                    state_d = ST_MEM_WAIT;
                    wait_d  = 8'd1;
                end else begin
                    run_rules_s = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (freeze_s) begin
                    ctrl_s = CTRL_OFF;
                    if (wait_q >= TIMEOUT) begin
                        state_d   = ST_HALT;
                        halted_d  = 1'b1;
                        mem_err_d = 1'b1;
                        wait_d    = 8'd0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    wait_d = 8'd0;
                    if (halt_req_s) begin
                        ctrl_s   = CTRL_OFF;
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        run_rules_s = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                // Resume takes priority over a syscall still sitting in WB
                if (resume) begin
                    ctrl_s    = CTRL_RESUME;
                    state_d   = ST_RUN;
                    halted_d  = 1'b0;
                    mem_err_d = 1'b0;
                end else begin
                    ctrl_s = CTRL_OFF;
                end
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = 8'd0;
            end
        endcase
        if (run_rules_s) begin
            if (branch_taken) begin
                ctrl_s  = CTRL_FLUSH;
                flush_d = sat_inc(flush_q);
            end else if (load_use_s) begin
                ctrl_s  = CTRL_STALL;
                stall_d = sat_inc(stall_q);
            end else begin
                ctrl_s = CTRL_RUN;
            end
        end else begin
            stall_d = stall_q;
        end
    end

    // State, wait counter, performance counters and halt flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            wait_q    <= 8'd0;
            stall_q   <= '0;
            flush_q   <= '0;
            halted_q  <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            halted_q  <= halted_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
            exmem_en, exmem_clr, memwb_en, memwb_clr} = ctrl_s;
    assign halted    = halted_q;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle behavioural model and
// hand-computed literal checkpoints.
module tb_pipe_hazard_ctrl;

    localparam int TMO   = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [8:0] V_RUN    = 9'b1_10_10_10_10;
    localparam logic [8:0] V_OFF    = 9'b0_00_00_00_00;
    localparam logic [8:0] V_FLUSH  = 9'b1_11_11_10_10;
    localparam logic [8:0] V_STALL  = 9'b0_00_11_10_10;
    localparam logic [8:0] V_RESUME = 9'b1_10_10_10_11;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_R1_pos, id_R2_pos, ex_dst;
    logic id_uses_R1, id_uses_R2, ex_mem_read, branch_taken;
    logic mem_req, mem_ready, wb_syscall, resume;
    logic [31:0] wb_v0;
    logic pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
    logic exmem_en, exmem_clr, memwb_en, memwb_clr, halted, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [8:0] ctrl;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: mode 0 = running, 1 = waiting on memory, 2 = halted
    int m_mode, m_wait, m_stall, m_flush;
    bit m_halted, m_err;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_R1_pos(id_R1_pos), .id_R2_pos(id_R2_pos),
        .id_uses_R1(id_uses_R1), .id_uses_R2(id_uses_R2),
        .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_syscall(wb_syscall), .wb_v0(wb_v0), .resume(resume),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr),
        .idex_en(idex_en), .idex_clr(idex_clr),
        .exmem_en(exmem_en), .exmem_clr(exmem_clr),
        .memwb_en(memwb_en), .memwb_clr(memwb_clr),
        .halted(halted), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctrl = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
                   exmem_en, exmem_clr, memwb_en, memwb_clr};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_load_use();
        return ex_mem_read && ex_dst != 5'd0 &&
               ((id_uses_R1 && id_R1_pos == ex_dst) || (id_uses_R2 && id_R2_pos == ex_dst));
    endfunction

    function automatic bit m_halt_req();
        return wb_syscall && wb_v0 == 32'd10;
    endfunction

    function automatic bit m_freeze();
        return mem_req && !mem_ready;
    endfunction

    function automatic logic [8:0] m_ctrl();
        if (m_mode == 2) return resume ? V_RESUME : V_OFF;
        if (m_halt_req() || m_freeze()) return V_OFF;
        if (branch_taken) return V_FLUSH;
        if (m_load_use()) return V_STALL;
        return V_RUN;
    endfunction

    // Model advance on each clock, reset asynchronously
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
            m_halted = 0; m_err = 0;
        end else if (m_mode == 2) begin
            if (resume) begin
                m_mode = 0; m_halted = 0; m_err = 0;
            end
        end else if (m_mode == 1 && m_freeze()) begin
            if (m_wait == TMO) begin
                m_mode = 2; m_halted = 1; m_err = 1; m_wait = 0;
            end else begin
                m_wait = m_wait + 1;
            end
        end else begin
            m_wait = 0;
            if (m_halt_req()) begin
                m_mode = 2; m_halted = 1;
            end else if (m_freeze()) begin
                m_mode = 1; m_wait = 1;
            end else begin
                m_mode = 0;
                if (branch_taken) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                else if (m_load_use()) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("ctrl_model", 32'(ctrl), 32'(m_ctrl()));
        chk("halted_model", 32'(halted), 32'(m_halted));
        chk("mem_err_model", 32'(mem_err), 32'(m_err));
        chk("stall_model", 32'(stall_cnt), 32'(m_stall));
        chk("flush_model", 32'(flush_cnt), 32'(m_flush));
    end

    task automatic idle();
        id_R1_pos = 5'd0; id_R2_pos = 5'd0; id_uses_R1 = 1'b0; id_uses_R2 = 1'b0;
        ex_dst = 5'd0; ex_mem_read = 1'b0; branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; wb_syscall = 1'b0; wb_v0 = 32'd0;
        resume = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu_r1(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_dst = r; id_uses_R1 = 1'b1; id_R1_pos = r;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 32'(ctrl), 32'(V_RUN));
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        next();
        rst_n = 1'b1;
        next();

        // Load-use on R1
        set_lu_r1(5'd5);
        @(negedge clk); chk("lu_ctrl", 32'(ctrl), 32'(V_STALL));
        next(); idle(); chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        // Destination $zero never stalls
        set_lu_r1(5'd0);
        @(negedge clk); chk("lu_zero_ctrl", 32'(ctrl), 32'(V_RUN));
        next(); idle(); chk("lu_zero_cnt", 32'(stall_cnt), 32'd1);
        // Load-use on R2
        ex_mem_read = 1'b1; ex_dst = 5'd7; id_uses_R2 = 1'b1; id_R2_pos = 5'd7;
        @(negedge clk); chk("lu_r2_ctrl", 32'(ctrl), 32'(V_STALL));
        next(); idle(); chk("lu_r2_cnt", 32'(stall_cnt), 32'd2);
        // Matching index but operand unused
        ex_mem_read = 1'b1; ex_dst = 5'd9; id_R1_pos = 5'd9; id_R2_pos = 5'd9;
        @(negedge clk); chk("lu_unused_ctrl", 32'(ctrl), 32'(V_RUN));
        next(); idle();
        // Branch together with load-use: flush only
        set_lu_r1(5'd3); branch_taken = 1'b1;
        @(negedge clk); chk("br_lu_ctrl", 32'(ctrl), 32'(V_FLUSH));
        next(); idle();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd2);

        // Three-cycle memory wait, then completion
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("memwait_ctrl", 32'(ctrl), 32'(V_OFF));
            next();
        end
        mem_ready = 1'b1;
        @(negedge clk); chk("memdone_ctrl", 32'(ctrl), 32'(V_RUN));
        next(); idle();
        @(negedge clk); chk("memdone_halted", 32'(halted), 32'd0);
        next();

        // Memory timeout
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (4) next();
        chk("tmo_not_yet", 32'(halted), 32'd0);
        next();
        chk("tmo_halted", 32'(halted), 32'd1);
        chk("tmo_mem_err", 32'(mem_err), 32'd1);
        idle();
        next();
        resume = 1'b1;
        @(negedge clk); chk("resume_ctrl", 32'(ctrl), 32'(V_RESUME));
        next(); idle();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_mem_err", 32'(mem_err), 32'd0);

        // Resume outside HALT has no effect
        resume = 1'b1;
        @(negedge clk); chk("stray_resume_ctrl", 32'(ctrl), 32'(V_RUN));
        next(); idle();

        // Syscall halt held for 10 cycles
        wb_syscall = 1'b1; wb_v0 = 32'd10;
        @(negedge clk); chk("sys_ctrl", 32'(ctrl), 32'(V_OFF));
        next(); idle();
        chk("sys_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("sys_hold_ctrl", 32'(ctrl), 32'(V_OFF));
            chk("sys_hold_halted", 32'(halted), 32'd1);
            next();
        end
        resume = 1'b1; wb_syscall = 1'b1; wb_v0 = 32'd10;
        @(negedge clk); chk("sys_resume_ctrl", 32'(ctrl), 32'(V_RESUME));
        next(); idle();
        chk("sys_resume_halted", 32'(halted), 32'd0);
        wb_syscall = 1'b1; wb_v0 = 32'd1;
        @(negedge clk); chk("sys_v0_1_ctrl", 32'(ctrl), 32'(V_RUN));
        next(); idle();
        chk("sys_v0_1_halted", 32'(halted), 32'd0);

        // Counter saturation
        set_lu_r1(5'd4);
        repeat ((1 << CW) + 3) next();
        idle();
        chk("stall_sat", 32'(stall_cnt), 32'd15);
        branch_taken = 1'b1;
        repeat (1 << CW) next();
        idle();
        chk("flush_sat", 32'(flush_cnt), 32'd15);

        // Reset in the middle of a memory wait
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (2) next();
        @(negedge clk); chk("mw_pre_ctrl", 32'(ctrl), 32'(V_OFF));
        next();
        idle();
        rst_n = 1'b0;
        #1;
        chk("mw_rst_ctrl", 32'(ctrl), 32'(V_RUN));
        chk("mw_rst_stall", 32'(stall_cnt), 32'd0);
        chk("mw_rst_flush", 32'(flush_cnt), 32'd0);
        next();
        rst_n = 1'b1;
        next();

        // Reset in the middle of a halt
        wb_syscall = 1'b1; wb_v0 = 32'd10;
        next(); idle();
        chk("halt_pre_rst", 32'(halted), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_ctrl", 32'(ctrl), 32'(V_RUN));
        next();
        rst_n = 1'b1;
        repeat (2) next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Drives the en/clr inputs of the four pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Handles load-use stalls, taken-branch flushes, memory-wait freezes with a timeout, and syscall halt/resume.
- Keeps saturating performance counters for stalls and flushes.

Parameters:
- MEM_TIMEOUT, 255: maximum number of consecutive memory-wait cycles before an error halt; range 1..255.
- CNT_W, 16: width of the stall and flush performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_R1_pos  in  5  rs index of the instruction in ID.
- id_R2_pos  in  5  rt index of the instruction in ID.
- id_uses_R1  in  1  the ID instruction reads R1.
- id_uses_R2  in  1  the ID instruction reads R2.
- ex_dst  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  the MEM stage is accessing data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- wb_syscall  in  1  the instruction at the MEM/WB output is a syscall.
- wb_v0  in  32  $v0 value accompanying the WB syscall.
- resume  in  1  single-cycle pulse that releases a halt.
- pc_en  out  1  PC write enable.
- ifid_en, ifid_clr  out  1 each  IF/ID buffer controls.
- idex_en, idex_clr  out  1 each  ID/EX buffer controls.
- exmem_en, exmem_clr  out  1 each  EX/MEM buffer controls.
- memwb_en, memwb_clr  out  1 each  MEM/WB buffer controls.
- halted  out  1  core is halted.
- mem_err  out  1  halt was caused by a memory timeout.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Buffers only honour clr when en=1. Every clr assertion therefore comes with en=1 on the same buffer.
- Enable/clear outputs are combinational from state and inputs. State, counters, halted and mem_err are registered.
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, halted=0, mem_err=0.
  - Combinational outputs follow the RUN defaults: all en=1, all clr=0.
- Derived conditions:
  - load_use = ex_mem_read & ex_dst!=0 & ((id_uses_R1 & id_R1_pos==ex_dst) | (id_uses_R2 & id_R2_pos==ex_dst)).
  - halt_req = wb_syscall & wb_v0==10.
  - freeze = mem_req & !mem_ready.
- States: RUN, MEM_WAIT, HALT.
- RUN, first matching rule applies:
  1. halt_req: all en=0. Next state HALT, halted<=1.
  2. freeze: all en=0. Next state MEM_WAIT, wait counter<=1.
  3. branch_taken: all en=1, ifid_clr=1, idex_clr=1. flush_cnt increments, saturating.
  4. load_use: pc_en=0, ifid_en=0, idex_en=1, idex_clr=1 (bubble); EX/MEM and MEM/WB enabled. stall_cnt increments, saturating.
  5. Otherwise: all en=1, all clr=0.
- A simultaneous branch_taken and load_use is handled as a flush only; stall_cnt does not change.
- MEM_WAIT:
  - While freeze holds, all en=0 and the wait counter increments.
  - When the counter reaches MEM_TIMEOUT with freeze still high: next state HALT, halted<=1, mem_err<=1.
  - When mem_ready=1 (or mem_req drops), apply the RUN rules 1 and 3–5 in that same cycle. Next state RUN, counter<=0.
- HALT:
  - All en=0; halted=1.
  - resume=1: all en=1 and memwb_clr=1, so the syscall leaves WB. halt_req is ignored this cycle. Next state RUN, halted<=0, mem_err<=0.
  - resume while not in HALT is ignored.
- Both counters hold at 2^CNT_W-1 once reached; they clear only on reset.
- Reset asserted mid-operation returns immediately to the RUN defaults, including in the middle of a MEM_WAIT or HALT.

Test Plan:
- Reset, then ex_mem_read=1, ex_dst=5, id_uses_R1=1, id_R1_pos=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_en=1, idex_clr=1; stall_cnt=1. Repeat with ex_dst=0 -> no stall.
- branch_taken=1 together with the load_use condition -> ifid_clr=1, idex_clr=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all en=0 for 3 cycles, then normal enables; state back to RUN.
- MEM_TIMEOUT=4, mem_req=1 held and mem_ready=0 -> halted=1 and mem_err=1 after the 4th wait cycle. resume pulse -> memwb_clr=1, halted=0, mem_err=0.
- wb_syscall=1, wb_v0=10 -> all en=0 that cycle, halted=1 next; holds 10 cycles. With wb_v0=1 instead -> no halt.
- Drive 2^CNT_W+3 load-use cycles with CNT_W=4 -> stall_cnt saturates at 15. Assert rst_n=0 in MEM_WAIT -> outputs return to RUN defaults immediately.
